// File: rtl/anim_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : anim_frame_seq
// Description : Frame index sequencer for the LED animation pattern decoders.
//               Programmable-rate playback with reverse, loop, pause and stop.
// Revision    : 1.0 - initial release
// ============================================================================
module anim_frame_seq #(
  parameter int TICK_DIV   = 12500000,
  parameter int FRAME_LAST = 31,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop,
  input  logic       rev,
  input  logic [1:0] speed,
  output logic [4:0] frame,
  output logic       step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_div  = CNT_W'(TICK_DIV);
  localparam logic [4:0]       c_last = 5'(FRAME_LAST);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_frame, w_frame_nxt;
  logic             r_step, w_step_nxt;
  logic             r_loop, w_loop_nxt;
  logic             r_rev, w_rev_nxt;
  logic [CNT_W-1:0] w_limit;
  logic             w_at_end;

  // Period is recomputed every cycle so speed changes take effect immediately.
  assign w_limit  = (c_div >> speed) - CNT_W'(1);
  assign w_at_end = r_rev ? (r_frame == 5'd0) : (r_frame == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_frame <= '0;
      r_step  <= 1'b0;
      r_loop  <= 1'b0;
      r_rev   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_frame <= w_frame_nxt;
      r_step  <= w_step_nxt;
      r_loop  <= w_loop_nxt;
      r_rev   <= w_rev_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    w_step_nxt  = 1'b0;
    w_loop_nxt  = r_loop;
    w_rev_nxt   = r_rev;

    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_frame_nxt = '0;
    end else if (start) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
      w_frame_nxt = rev ? c_last : 5'd0;
      w_step_nxt  = 1'b1;
      w_loop_nxt  = loop;
      w_rev_nxt   = rev;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!pause) begin
            if (r_cnt >= w_limit) begin
              w_cnt_nxt = '0;
              if (!w_at_end) begin
                w_frame_nxt = r_rev ? (r_frame - 5'd1) : (r_frame + 5'd1);
                w_step_nxt  = 1'b1;
              end else if (r_loop) begin
                w_frame_nxt = r_rev ? c_last : 5'd0;
                w_step_nxt  = 1'b1;
              end else begin
                // One-shot end: frame holds its final value in DONE.
                w_state_nxt = ST_DONE;
              end
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: w_cnt_nxt = '0;
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign frame = r_frame;
  assign step  = r_step;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_anim_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_anim_frame_seq
// Description : Scoreboard bench for anim_frame_seq; expected step events are
//               computed arithmetically from start time, period and direction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anim_frame_seq;

  localparam int TICK_DIV = 8;
  localparam int FL       = 31;
  localparam int NF       = FL + 1;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, loop, rev;
  logic [1:0] speed;
  logic [4:0] frame;
  logic       step, busy, done;

  anim_frame_seq #(.TICK_DIV(TICK_DIV), .FRAME_LAST(FL), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop(loop), .rev(rev), .speed(speed), .frame(frame), .step(step),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int q_t[$];
  int q_f[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every step pulse must match the oldest expected (cycle, frame).
  always @(negedge clk) begin
    if (step !== 1'b0) begin
      if (q_t.size() == 0) chk("unexpected_step", 1, 0);
      else begin
        chk("step_time", cyc, q_t.pop_front());
        chk("step_frame", int'(frame), q_f.pop_front());
      end
    end
  end

  function automatic int period(input int s);
    return TICK_DIV >> s;
  endfunction

  function automatic int fval(input bit r, input int k);
    return r ? FL - (k % NF) : (k % NF);
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic push(input int t, input int f);
    q_t.push_back(t);
    q_f.push_back(f);
  endtask

  task automatic launch(input bit lp, input bit rv, input int s, output int st);
    loop  = lp;
    rev   = rv;
    speed = 2'(s);
    start = 1'b1;
    st    = cyc + 1;
  endtask

  task automatic after_start(input bit rv, input int st);
    wait_to(st);
    start = 1'b0;
    chk("start_frame", int'(frame), rv ? FL : 0);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
  endtask

  // Plays L cycles from a start pulse with stable speed and no pause.
  task automatic seg_run(input bit lp, input bit rv, input int s, input int L);
    int st, p, k, e, de;
    p = period(s);
    launch(lp, rv, s, st);
    for (int i = 0; st + i * p <= st + L - 1; i++) begin
      if (!lp && i > FL) break;
      push(st + i * p, fval(rv, i));
    end
    after_start(rv, st);
    wait_to(st + L - 1);
    e  = L - 1;
    k  = e / p;
    de = (!lp && e >= NF * p) ? 1 : 0;
    if (!lp && k > FL) k = FL;
    chk("end_frame", int'(frame), fval(rv, k));
    chk("end_done", int'(done), de);
    chk("end_busy", int'(busy), 1 - de);
    chk("pending_steps", q_t.size(), 0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    wait_to(cyc + 1);
    stop = 1'b0;
    chk("stop_idle", int'({frame, busy, done}), 0);
    chk("stop_step", int'(step), 0);
  endtask

  initial begin
    int st;
    rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0;
    loop = 1'b0; rev = 1'b0; speed = 2'd0;

    // Reset held with start asserted.
    wait_to(1);
    for (int i = 0; i < 3; i++) begin
      chk("reset_outputs", int'({frame, step, busy, done}), 0);
      wait_to(cyc + 1);
    end
    rst = 1'b0; start = 1'b0;
    wait_to(cyc + 1);
    chk("post_reset", int'({frame, step, busy, done}), 0);

    // One-shot forward through done, then loop reverse at P=2.
    seg_run(1'b0, 1'b0, 0, 270);
    seg_run(1'b1, 1'b1, 2, 140);

    // Pause for 20 cycles at cnt=3 during frame 5.
    launch(1'b0, 1'b0, 0, st);
    for (int k = 0; k <= 5; k++) push(st + 8 * k, k);
    for (int k = 6; k <= 9; k++) push(st + 68 + 8 * (k - 6), k);
    after_start(1'b0, st);
    wait_to(st + 43);
    pause = 1'b1;
    wait_to(st + 55);
    chk("pause_frame", int'(frame), 5);
    chk("pause_busy", int'(busy), 1);
    wait_to(st + 63);
    pause = 1'b0;
    wait_to(st + 95);
    chk("pause_end_frame", int'(frame), 9);
    chk("pending_steps", q_t.size(), 0);

    // start and stop together at frame 12: stop wins, start ignored.
    seg_run(1'b1, 1'b0, 0, 99);
    start = 1'b1; stop = 1'b1;
    wait_to(cyc + 1);
    start = 1'b0; stop = 1'b0;
    chk("abort_idle", int'({frame, busy, done}), 0);
    wait_to(cyc + 1);
    chk("abort_stays_idle", int'({frame, step, busy, done}), 0);

    // rst mid-run at frame 12.
    seg_run(1'b1, 1'b0, 0, 99);
    rst = 1'b1;
    wait_to(cyc + 1);
    rst = 1'b0;
    chk("rst_abort_idle", int'({frame, step, busy, done}), 0);

    // Speed 0 -> 3 at cnt=5 of frame 2: one frame per cycle thereafter.
    launch(1'b0, 1'b0, 0, st);
    for (int k = 0; k <= 2; k++) push(st + 8 * k, k);
    for (int k = 3; k <= FL; k++) push(st + 19 + k, k);
    after_start(1'b0, st);
    wait_to(st + 21);
    speed = 2'd3;
    wait_to(st + 55);
    chk("speed_end_frame", int'(frame), FL);
    chk("speed_done", int'(done), 1);
    chk("speed_busy", int'(busy), 0);
    chk("pending_steps", q_t.size(), 0);

    // Random segments; the first restarts from DONE.
    for (int i = 0; i < 16; i++) begin
      seg_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) do_stop();
    end
    do_stop();
    wait_to(cyc + 2);
    chk("final_pending", q_t.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/anim_frame_seq.md
Name: anim_frame_seq

Overview:
- Timing and sequencing engine that drives the 5-bit frame index into the LED animation pattern decoders (DEC-series 7-segment pattern tables).
- Steps the index through 0..FRAME_LAST at a programmable frame rate.
- Supports forward or reverse play, loop or one-shot mode, pause, and stop.
- Sits between the board clock/user controls and the combinational pattern decoders.

Parameters:
- TICK_DIV, 12500000: frame period in clk cycles at speed=0. Must be ≥8.
- FRAME_LAST, 31: last frame index. Range 1..31.
- CNT_W, 24: prescaler counter width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse. Starts or restarts playback.
- stop, input, 1: one-cycle pulse. Aborts playback and returns to idle.
- pause, input, 1: level. While high, the frame timer is frozen.
- loop, input, 1: 1 = wrap continuously; 0 = one-shot. Sampled on start.
- rev, input, 1: 1 = play FRAME_LAST down to 0; 0 = play 0 up to FRAME_LAST. Sampled on start.
- speed, input, 2: frame period = TICK_DIV >> speed. Evaluated live.
- frame, output, 5: frame index to the pattern decoder input.
- step, output, 1: one-cycle pulse coincident with every new frame value.
- busy, output, 1: high while in RUN.
- done, output, 1: high in DONE after a one-shot sequence completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE.
  - frame=0, step=0, busy=0, done=0.
  - Prescaler cnt=0; latched loop_r=0, rev_r=0.
  - rst overrides every other input.
- States: IDLE, RUN, DONE (2-bit encoding).
- Priority each cycle: rst > stop > start > timer.
- stop (any state):
  - Next cycle: IDLE, frame=0, cnt=0, done=0, busy=0, step=0.
  - start in the same cycle is ignored.
- start (any state, no stop):
  - Latch loop_r=loop, rev_r=rev.
  - Next cycle: RUN, busy=1, done=0, cnt=0, step=1.
  - frame = FRAME_LAST if rev=1, else 0.
  - Restarting from RUN or DONE behaves identically.
- RUN, pause=0:
  - period P = TICK_DIV >> speed.
  - If cnt ≥ P-1: cnt←0 and the frame advances. Otherwise cnt←cnt+1.
  - The ≥ compare means a mid-frame speed increase advances on the next cycle; it never waits for counter wrap.
- RUN, pause=1:
  - cnt and frame hold; step=0.
  - start, stop and rst remain effective.
- Frame advance (not at end): frame ±1 per rev_r; step=1 for exactly that cycle.
- End of sequence (frame==FRAME_LAST with rev_r=0, or frame==0 with rev_r=1):
  - loop_r=1: wrap to 0 (forward) or FRAME_LAST (reverse); step=1; stay in RUN.
  - loop_r=0: go to DONE; frame holds its end value; step=0; busy=0; done=1.
- DONE:
  - frame, done and busy hold; cnt=0.
  - Leaves only on start, stop or rst.
- Latency:
  - First frame appears 1 cycle after start.
  - Each later frame lasts exactly P cycles when speed is stable and pause=0.
  - In one-shot mode the last frame also lasts P cycles before done rises.
- step is never high in two consecutive cycles when P ≥ 2. It may be continuously high when P=1.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All tests use TICK_DIV=8, FRAME_LAST=31.
1. Reset: hold rst 3 cycles with start=1 → frame=0, step=0, busy=0, done=0 throughout, and 1 cycle after rst deasserts.
2. One-shot forward (start pulse at cycle 0; loop=0, rev=0, speed=0):
   - frame=0 at cycle 1; frame=1 at cycle 9; frame=31 at cycle 249.
   - done=1 and busy=0 at cycle 257; frame stays 31.
   - Exactly 32 step pulses in total.
3. Loop reverse (loop=1, rev=1, speed=2, P=2):
   - frame sequence 31,30,…,0,31,30 at 2-cycle spacing.
   - step pulses on the 0→31 wrap; done stays 0; busy stays 1.
4. Pause mid-run: assert pause for 20 cycles at cnt=3 during frame 5 → frame stays 5, no step; after release, frame 6 appears exactly 5 cycles later.
5. Abort cases, both from RUN at frame 12 → next cycle frame=0, busy=0, done=0, IDLE:
   - start and stop in the same cycle;
   - separately, rst mid-run.
6. Live speed change: speed 0→3 while cnt=5 → frame advances the following cycle; thereafter one frame per cycle with step held high. From DONE, a start pulse restarts cleanly and clears done.
